mmsa_out_serializer: RTL and testbench

Output stage of the MMSA core, sitting between the systolic-array accumulator drain and the `out_valid`/`out_value` pad pair. It accepts parallel result words over a valid/ready handshake and buffers them in a small FIFO. Each word is emitted on the single-bit `out_value` line as a self-describing frame: a fixed-width bit-length header, then the significant bits of the value, both MSB-first. `out_valid` frames every emitted bit, so the off-chip bench can decode variable-length results with no side channel.

---
 rtl/mmsa_out_serializer.sv | 151 +++++++++++++++
 tb/tb_mmsa_out_serializer.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/mmsa_out_serializer.sv
// mmsa_out_serializer
//   Output stage of the MMSA core. Result words arrive over a valid/ready
//   handshake into a small FIFO. Each word is sent on a single serial line
//   as a self-describing frame: a LEN_W-bit header holding the bit length
//   L of the value, then the L significant value bits, both MSB-first.
//
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   res_valid  upstream word valid
//   res_data   upstream word (unsigned, DATA_W bits)
//   res_ready  FIFO not full (depends only on the stored count)
//   out_valid  registered, high on every cycle carrying a frame bit
//   out_value  registered serial bit, 0 whenever out_valid is 0
//   busy       FIFO non-empty or a frame in flight
module mmsa_out_serializer #(
    parameter int DATA_W = 40,
    parameter int LEN_W  = 6,
    parameter int DEPTH  = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              res_valid,
    input  logic [DATA_W-1:0] res_data,
    output logic              res_ready,
    output logic              out_valid,
    output logic              out_value,
    output logic              busy
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    typedef enum logic [1:0] {IDLE, HDR, VAL} state_t;

    // FIFO storage and bookkeeping
    logic [DATA_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wr_ptr, rd_ptr;
    logic [CNT_W-1:0]  count;
    logic              full, empty, push, pop;

    // Serializer state
    state_t            state;
    logic [LEN_W-1:0]  bit_cnt;
    logic [LEN_W-1:0]  len_reg;
    logic [LEN_W-1:0]  hdr_sh;
    logic [DATA_W-1:0] val_sh;

    // Head-of-FIFO decode
    logic [DATA_W-1:0] head;
    logic [LEN_W-1:0]  head_len;
    logic [LEN_W-1:0]  head_shamt;
    logic [DATA_W-1:0] head_aligned;

    assign full      = (count == CNT_W'(DEPTH));
    assign empty     = (count == '0);
    assign res_ready = !full;
    assign push      = res_valid && !full;
    // A pop happens from IDLE, or on the last value bit so frames abut.
    assign pop       = !empty && ((state == IDLE) || (state == VAL && bit_cnt == '0));
    assign busy      = !empty || (state != IDLE);

    assign head = mem[rd_ptr];

    // Leading-one detect; a zero word still sends one bit.
    always_comb begin
        head_len = LEN_W'(1);
        for (int i = 0; i < DATA_W; i++) begin
            if (head[i]) head_len = LEN_W'(i + 1);
        end
    end

    // Left-justify the value so the shifter MSB is bit L-1 at frame start.
    assign head_shamt   = LEN_W'(DATA_W) - head_len;
    assign head_aligned = head << head_shamt;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= res_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Output bits are registered: the bit shown while in a state is the one
    // loaded on the transition into that cycle, so bit_cnt indexes the bit
    // currently on the line.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            bit_cnt   <= '0;
            len_reg   <= '0;
            hdr_sh    <= '0;
            val_sh    <= '0;
            out_valid <= 1'b0;
            out_value <= 1'b0;
        end else begin
            case (state)
                IDLE, VAL: begin
                    if (state == VAL && bit_cnt != '0) begin
                        bit_cnt   <= bit_cnt - 1'b1;
                        out_value <= val_sh[DATA_W-1];
                        val_sh    <= val_sh << 1;
                    end else if (pop) begin
                        state     <= HDR;
                        bit_cnt   <= LEN_W'(LEN_W - 1);
                        len_reg   <= head_len;
                        hdr_sh    <= head_len << 1;
                        val_sh    <= head_aligned;
                        out_valid <= 1'b1;
                        out_value <= head_len[LEN_W-1];
                    end else begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        out_value <= 1'b0;
                    end
                end
                HDR: begin
                    if (bit_cnt == '0) begin
                        state     <= VAL;
                        bit_cnt   <= len_reg - 1'b1;
                        out_value <= val_sh[DATA_W-1];
                        val_sh    <= val_sh << 1;
                    end else begin
                        bit_cnt   <= bit_cnt - 1'b1;
                        out_value <= hdr_sh[LEN_W-1];
                        hdr_sh    <= hdr_sh << 1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_value <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mmsa_out_serializer.sv
module tb_mmsa_out_serializer;
    localparam int DW = 40;
    localparam int LW = 6;
    localparam int D  = 4;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          res_valid = 1'b0;
    logic [DW-1:0] res_data = '0;
    logic          res_ready, out_valid, out_value, busy;

    mmsa_out_serializer #(.DATA_W(DW), .LEN_W(LW), .DEPTH(D)) dut (
        .clk(clk), .rst_n(rst_n), .res_valid(res_valid), .res_data(res_data),
        .res_ready(res_ready), .out_valid(out_valid), .out_value(out_value), .busy(busy)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int errors  = 0;
    int cyc     = 0;
    always @(posedge clk) cyc++;

    // ---------------- behavioural model ----------------
    logic [DW-1:0] pend[$];   // accepted, not yet started words
    bit            fb[$];     // remaining bits of the frame in flight
    bit            exp_v, exp_o;

    function automatic int lenf(logic [DW-1:0] v);
        longint unsigned x;
        x = 64'(v);
        return (x == 0) ? 1 : $clog2(x + 1);
    endfunction

    function automatic void build(logic [DW-1:0] v);
        int l;
        l = lenf(v);
        for (int i = LW - 1; i >= 0; i--) fb.push_back(((l >> i) & 1) == 1);
        for (int i = l - 1; i >= 0; i--)  fb.push_back(v[i]);
    endfunction

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pend.delete();
            fb.delete();
            exp_v = 0;
            exp_o = 0;
        end else begin
            bit rdy;
            rdy = pend.size() < D;
            if (fb.size() == 0 && pend.size() > 0) build(pend.pop_front());
            if (fb.size() > 0) begin
                exp_v = 1;
                exp_o = fb.pop_front();
            end else begin
                exp_v = 0;
                exp_o = 0;
            end
            if (res_valid && rdy) pend.push_back(res_data);
        end
    end

    // ---------------- compare + capture ----------------
    bit dlog[$];
    int first_cyc, last_cyc, push_cyc;
    bit saw_full;

    always @(negedge clk) begin
        bit eb, er;
        eb = (pend.size() > 0) || exp_v;
        er = pend.size() < D;
        vectors++;
        if (out_valid !== exp_v) begin errors++; $display("FAIL out_valid cyc=%0d got=%b exp=%b", cyc, out_valid, exp_v); end
        if (out_value !== exp_o) begin errors++; $display("FAIL out_value cyc=%0d got=%b exp=%b", cyc, out_value, exp_o); end
        if (busy !== eb)         begin errors++; $display("FAIL busy cyc=%0d got=%b exp=%b", cyc, busy, eb); end
        if (res_ready !== er)    begin errors++; $display("FAIL res_ready cyc=%0d got=%b exp=%b", cyc, res_ready, er); end
        if (out_valid === 1'b1) begin
            if (dlog.size() == 0) first_cyc = cyc;
            dlog.push_back(out_value);
            last_cyc = cyc;
        end
        if (res_valid && !res_ready) saw_full = 1;
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", name, act, exp);
        end
    endtask

    function automatic logic [63:0] packlog();
        logic [63:0] r;
        r = '0;
        foreach (dlog[i]) r = {r[62:0], dlog[i]};
        return r;
    endfunction

    task automatic push(input logic [DW-1:0] v);
        int n;
        bit acc;
        res_valid = 1;
        res_data  = v;
        n = 0;
        do begin
            acc = res_ready;
            if (acc) push_cyc = cyc;
            @(negedge clk);
            n++;
        end while (!acc && n < 200);
        if (!acc) begin
            errors++;
            $display("FAIL push_timeout word=%0h", v);
        end
    endtask

    task automatic wait_idle();
        int n;
        res_valid = 0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (busy && n < 2000);
        if (busy) begin
            errors++;
            $display("FAIL idle_timeout busy=%b", busy);
        end
        @(negedge clk);
    endtask

    task automatic clr();
        dlog.delete();
    endtask

    logic [63:0] expv;
    int          tot;
    logic [63:0] tmp;

    initial begin
        rst_n = 1;
        #1 rst_n = 0;
        @(negedge clk);
        chk("reset_ready", 64'(res_ready), 64'd1);
        chk("reset_valid", 64'(out_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        @(negedge clk);
        rst_n = 1;
        @(negedge clk);

        // Single small word
        clr();
        push(40'd5);
        wait_idle();
        chk("five_len", 64'(dlog.size()), 64'd9);
        chk("five_bits", packlog(), 64'b000011_101);
        chk("five_latency", 64'(first_cyc - push_cyc), 64'd2);

        // Zero
        clr();
        push(40'd0);
        wait_idle();
        chk("zero_len", 64'(dlog.size()), 64'd7);
        chk("zero_bits", packlog(), 64'b000001_0);

        // Maximum
        clr();
        push({DW{1'b1}});
        wait_idle();
        chk("max_len", 64'(dlog.size()), 64'd46);
        chk("max_bits", packlog(), 64'h28_FFFF_FFFF_FF);

        // Back-to-back
        clr();
        push(40'd1);
        push(40'd6);
        push(40'h80);
        wait_idle();
        expv = {34'd0, 7'b000001_1, 9'b000011_110, 14'b001000_10000000};
        chk("b2b_len", 64'(dlog.size()), 64'd30);
        chk("b2b_span", 64'(last_cyc - first_cyc + 1), 64'd30);
        chk("b2b_bits", packlog(), expv);

        // Backpressure: 6 words with valid held
        clr();
        saw_full = 0;
        tot = 0;
        for (int i = 0; i < 6; i++) begin
            push(40'h1234 + 40'(i * 37));
            tot += LW + lenf(40'h1234 + 40'(i * 37));
        end
        wait_idle();
        chk("bp_ready_fell", 64'(saw_full), 64'd1);
        chk("bp_total_bits", 64'(dlog.size()), 64'(tot));

        // Reset mid-frame
        clr();
        push(40'h3FF);
        res_valid = 0;
        repeat (9) @(posedge clk);
        #2 rst_n = 0;
        #1;
        chk("rst_async_valid", 64'(out_valid), 64'd0);
        chk("rst_async_value", 64'(out_value), 64'd0);
        chk("rst_async_ready", 64'(res_ready), 64'd1);
        repeat (2) @(negedge clk);
        rst_n = 1;
        clr();
        repeat (5) @(negedge clk);
        chk("post_rst_quiet", 64'(dlog.size()), 64'd0);
        push(40'd2);
        wait_idle();
        chk("post_rst_len", 64'(dlog.size()), 64'd8);
        chk("post_rst_bits", packlog(), 64'b000010_10);

        // Randomized traffic, upstream holds data while stalled
        for (int c = 0; c < 600; c++) begin
            if (!(res_valid && !res_ready)) begin
                res_valid = ($urandom_range(0, 3) != 0);
                tmp = {$urandom, $urandom};
                res_data = DW'(tmp >> $urandom_range(0, 63));
            end
            @(negedge clk);
        end
        wait_idle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
